// File: rtl/m3_cmd_gen.sv
// ============================================================================
// Module      : m3_cmd_gen
// Description : Button front-end for the m3 motor core. It synchronizes and
//               debounces the buttons, then drives run, stop and direction
//               levels and auto-repeating speed/power pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m3_cmd_gen #(
   parameter int DEBOUNCE_LEN = 16,
   parameter int REPEAT_DELAY = 5000,
   parameter int REPEAT_RATE  = 1000
) (
   input  logic clkI,
   input  logic rstI,
   input  logic btnStartI,
   input  logic btnStopI,
   input  logic btnDirI,
   input  logic btnSpdUpI,
   input  logic btnSpdDnI,
   input  logic btnPwrUpI,
   input  logic btnPwrDnI,
   output logic m3startO,
   output logic m3forceStopO,
   output logic m3invRotateO,
   output logic m3speedINCo,
   output logic m3speedDECo,
   output logic m3powerINCo,
   output logic m3powerDECo
);

   localparam int          NBTN       = 7;
   localparam logic [19:0] DB_LAST    = 20'(DEBOUNCE_LEN - 1);
   localparam logic [23:0] DELAY_LAST = 24'(REPEAT_DELAY - 1);
   localparam logic [23:0] RATE_LAST  = 24'(REPEAT_RATE - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DELAY = 2'd1;
   localparam logic [1:0] S_RPT   = 2'd2;

   // Bit order: 0 start, 1 dir, 2 spd up, 3 spd dn, 4 pwr up, 5 pwr dn, 6 stop.
   // Stop is last because it is the only level-only button (no edge detect).
   logic [NBTN-1:0] raw;
   logic [NBTN-1:0] sync1;
   logic [NBTN-1:0] sync2;
   logic [NBTN-1:0] stable;
   logic [5:0]      stable_d;
   logic [5:0]      press;
   logic [1:0]      pulse_inc;
   logic [1:0]      pulse_dec;

   assign raw = {btnStopI, btnPwrDnI, btnPwrUpI, btnSpdDnI, btnSpdUpI,
                 btnDirI, btnStartI};

   always_ff @(posedge clkI) begin
      if (rstI) begin
         sync1    <= '0;
         sync2    <= '0;
         stable_d <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_d <= stable[5:0];
      end
   end

   assign press = stable[5:0] & ~stable_d;

   for (genvar i = 0; i < NBTN; i++) begin : g_btn
      logic [19:0] db_cnt;
      logic        stable_bit;

      always_ff @(posedge clkI) begin
         if (rstI) begin
            db_cnt     <= '0;
            stable_bit <= 1'b0;
         end else if (sync2[i] == stable_bit) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable_bit <= sync2[i];
            db_cnt     <= '0;
         end else begin
            db_cnt <= db_cnt + 20'd1;
         end
      end

      assign stable[i] = stable_bit;
   end

   // Stop overrides start; direction may only flip while stopped.
   always_ff @(posedge clkI) begin
      if (rstI) begin
         m3startO     <= 1'b0;
         m3forceStopO <= 1'b0;
         m3invRotateO <= 1'b0;
      end else begin
         m3forceStopO <= stable[6];
         if (stable[6])
            m3startO <= 1'b0;
         else if (press[0])
            m3startO <= ~m3startO;
         if (press[1] && !m3startO)
            m3invRotateO <= ~m3invRotateO;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_pair
      localparam int UP = 2 + 2 * k;
      localparam int DN = 3 + 2 * k;

      logic [1:0]  state;
      logic [1:0]  state_nxt;
      logic [23:0] cnt;
      logic        dir_up;
      logic        dir_up_nxt;
      logic        cnt_clr;
      logic        cnt_inc;
      logic        fire;
      logic        fire_inc;
      logic        fire_dec;
      logic        inc_q;
      logic        dec_q;
      logic        active;
      logic        other;

      always_ff @(posedge clkI) begin
         if (rstI) begin
            state  <= S_IDLE;
            dir_up <= 1'b0;
            cnt    <= '0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
         end else begin
            state  <= state_nxt;
            dir_up <= dir_up_nxt;
            if (cnt_clr)
               cnt <= '0;
            else if (cnt_inc)
               cnt <= cnt + 24'd1;
            inc_q <= fire_inc;
            dec_q <= fire_dec;
         end
      end

      always_comb begin
         state_nxt  = state;
         dir_up_nxt = dir_up;
         cnt_clr    = 1'b0;
         cnt_inc    = 1'b0;
         fire       = 1'b0;
         active     = dir_up ? stable[UP] : stable[DN];
         other      = dir_up ? stable[DN] : stable[UP];
         case (state)
            S_IDLE: begin
               if (press[UP] && !stable[DN]) begin
                  fire       = 1'b1;
                  dir_up_nxt = 1'b1;
                  cnt_clr    = 1'b1;
                  state_nxt  = S_DELAY;
               end else if (press[DN] && !stable[UP]) begin
                  fire       = 1'b1;
                  dir_up_nxt = 1'b0;
                  cnt_clr    = 1'b1;
                  state_nxt  = S_DELAY;
               end
            end
            S_DELAY, S_RPT: begin
               if (!active || other) begin
                  cnt_clr   = 1'b1;
                  state_nxt = S_IDLE;
               end else if (cnt == ((state == S_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                  fire      = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = S_RPT;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: begin
               cnt_clr   = 1'b1;
               state_nxt = S_IDLE;
            end
         endcase
      end

      always_comb begin
         fire_inc = fire & dir_up_nxt;
         fire_dec = fire & ~dir_up_nxt;
      end

      assign pulse_inc[k] = inc_q;
      assign pulse_dec[k] = dec_q;
   end

   assign m3speedINCo = pulse_inc[0];
   assign m3speedDECo = pulse_dec[0];
   assign m3powerINCo = pulse_inc[1];
   assign m3powerDECo = pulse_dec[1];

endmodule

`default_nettype wire

// File: tb/tb_m3_cmd_gen.sv
// ============================================================================
// Module      : tb_m3_cmd_gen
// Description : Directed self-checking bench for m3_cmd_gen (DEBOUNCE_LEN=4,
//               REPEAT_DELAY=20, REPEAT_RATE=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m3_cmd_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic b_start = 1'b0, b_stop = 1'b0, b_dir = 1'b0;
   logic b_su = 1'b0, b_sd = 1'b0, b_pu = 1'b0, b_pd = 1'b0;
   logic o_start, o_fs, o_inv, o_si, o_sd, o_pi, o_pd;
   logic [6:0] outs;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   m3_cmd_gen #(
      .DEBOUNCE_LEN (4),
      .REPEAT_DELAY (20),
      .REPEAT_RATE  (8)
   ) dut (
      .clkI         (clk),
      .rstI         (rst),
      .btnStartI    (b_start),
      .btnStopI     (b_stop),
      .btnDirI      (b_dir),
      .btnSpdUpI    (b_su),
      .btnSpdDnI    (b_sd),
      .btnPwrUpI    (b_pu),
      .btnPwrDnI    (b_pd),
      .m3startO     (o_start),
      .m3forceStopO (o_fs),
      .m3invRotateO (o_inv),
      .m3speedINCo  (o_si),
      .m3speedDECo  (o_sd),
      .m3powerINCo  (o_pi),
      .m3powerDECo  (o_pd)
   );

   assign outs = {o_start, o_fs, o_inv, o_si, o_sd, o_pi, o_pd};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   // Cycle 0 is the first cycle with reset low.
   task automatic do_reset();
      rst = 1'b1;
      {b_start, b_stop, b_dir, b_su, b_sd, b_pu, b_pd} = '0;
      step();
      step();
      check_val("reset_outs", 32'(outs), 32'h0);
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      // Start: held from 10 -> toggles at 17; 3-cycle glitch ignored.
      do_reset();
      run_to(10);
      b_start = 1'b1;
      run_to(16);
      check_val("start_c16", 32'(o_start), 32'd0);
      step();
      check_val("start_c17", 32'(o_start), 32'd1);
      run_to(30);
      b_start = 1'b0;
      run_to(40);
      b_start = 1'b1;
      run_to(43);
      b_start = 1'b0;
      run_to(55);
      check_val("glitch_hold", 32'(o_start), 32'd1);
      run_to(60);
      b_start = 1'b1;
      run_to(66);
      check_val("start2_c66", 32'(o_start), 32'd1);
      step();
      check_val("start2_c67", 32'(o_start), 32'd0);

      // Speed up: pulses at 17, 37, 45; released so stable drops at 50.
      do_reset();
      for (int c = 0; c <= 70; c++) begin
         if (c == 10) b_su = 1'b1;
         if (c == 44) b_su = 1'b0;
         check_val("spd_inc", 32'(o_si), 32'(c == 17 || c == 37 || c == 45));
         check_val("spd_dec", 32'(o_sd), 32'd0);
         step();
      end

      // Power: both pressed stops repeats; re-press needed after release.
      do_reset();
      for (int c = 0; c <= 112; c++) begin
         if (c == 10)  b_pu = 1'b1;
         if (c == 40)  b_pd = 1'b1;
         if (c == 60)  b_pd = 1'b0;
         if (c == 90)  b_pu = 1'b0;
         if (c == 100) b_pu = 1'b1;
         check_val("pwr_inc", 32'(o_pi), 32'(c == 17 || c == 37 || c == 45 || c == 107));
         check_val("pwr_dec", 32'(o_pd), 32'd0);
         step();
      end

      // Stop forces start low; start presses during stop ignored.
      do_reset();
      run_to(10);
      b_start = 1'b1;
      run_to(20);
      b_start = 1'b0;
      run_to(30);
      b_stop = 1'b1;
      run_to(36);
      check_val("stop_c36", 32'({o_start, o_fs}), 32'b10);
      step();
      check_val("stop_c37", 32'({o_start, o_fs}), 32'b01);
      run_to(40);
      b_start = 1'b1;
      run_to(50);
      check_val("start_in_stop", 32'(o_start), 32'd0);
      run_to(60);
      b_stop = 1'b0;
      run_to(67);
      check_val("stop_rel_c67", 32'({o_start, o_fs}), 32'b00);
      run_to(70);
      b_start = 1'b0;
      run_to(80);
      b_start = 1'b1;
      b_stop  = 1'b1;
      run_to(87);
      check_val("same_cyc_c87", 32'({o_start, o_fs}), 32'b01);
      run_to(95);
      check_val("same_cyc_c95", 32'(o_start), 32'd0);

      // Direction: ignored while running, toggles once when stopped.
      do_reset();
      run_to(10);
      b_start = 1'b1;
      run_to(20);
      b_dir = 1'b1;
      run_to(30);
      check_val("dir_running", 32'({o_start, o_inv}), 32'b10);
      b_dir   = 1'b0;
      b_start = 1'b0;
      run_to(40);
      b_stop = 1'b1;
      run_to(50);
      b_stop = 1'b0;
      run_to(60);
      b_dir = 1'b1;
      run_to(66);
      check_val("dir_c66", 32'({o_start, o_inv}), 32'b00);
      step();
      check_val("dir_c67", 32'(o_inv), 32'd1);
      run_to(90);
      check_val("dir_once", 32'(o_inv), 32'd1);

      // Speed down held; one-cycle reset during repeat at cycle 55.
      do_reset();
      for (int c = 0; c <= 75; c++) begin
         if (c == 10) b_sd = 1'b1;
         rst = (c == 55);
         if (c == 56)
            check_val("rst_outs", 32'(outs), 32'h0);
         check_val("sdn_dec", 32'(o_sd),
                   32'(c == 17 || c == 37 || c == 45 || c == 53 || c == 63));
         check_val("sdn_inc", 32'(o_si), 32'd0);
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
